// File: rtl/issue_select_pkg.sv
// Shared scheduler sizing and row/FU typedefs for the issue select stage.
package issue_select_pkg;

    localparam int SCHED_ROWS   = 8;
    localparam int NUM_FU_TYPES = 4;

    typedef logic [$clog2(SCHED_ROWS)-1:0]   sched_row_t;
    typedef logic [$clog2(NUM_FU_TYPES)-1:0] fu_type_t;

endpackage

// File: rtl/issue_select_age_matrix.sv
// Relative-age tracking for scheduler rows; older[r][c] = row r allocated before row c.
module age_matrix
    import issue_select_pkg::*;
#(
    parameter int NUM_ROWS = SCHED_ROWS
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clear,
    input  logic                        alloc_en,
    input  logic [$clog2(NUM_ROWS)-1:0] alloc_row,
    input  logic [NUM_ROWS-1:0]         valid,
    input  logic [NUM_ROWS-1:0]         dealloc,
    input  logic [NUM_ROWS-1:0]         cand,
    output logic [NUM_ROWS-1:0]         oldest_onehot
);

    localparam int RW = $clog2(NUM_ROWS);

    logic [NUM_ROWS-1:0][NUM_ROWS-1:0] older;

    // Alloc beats dealloc on the same row; freed rows drop their age links.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            older <= '0;
        end else begin
            for (int r = 0; r < NUM_ROWS; r++) begin
                for (int c = 0; c < NUM_ROWS; c++) begin
                    if (alloc_en && alloc_row == RW'(c) && r != c)
                        older[r][c] <= valid[r];
                    else if (alloc_en && alloc_row == RW'(r))
                        older[r][c] <= 1'b0;
                    else if (dealloc[r] || dealloc[c])
                        older[r][c] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        oldest_onehot = '0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            oldest_onehot[r] = cand[r];
            for (int c = 0; c < NUM_ROWS; c++)
                if (cand[c] && older[c][r]) oldest_onehot[r] = 1'b0;
        end
    end

endmodule

// File: rtl/issue_select.sv
// Oldest-first single-issue select with a registered issue/free output stage.
module issue_select
    import issue_select_pkg::*;
#(
    parameter int NUM_ROWS = SCHED_ROWS,
    parameter int NUM_FUS  = NUM_FU_TYPES
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        alloc_en,
    input  logic [$clog2(NUM_ROWS)-1:0] alloc_row,
    input  logic [$clog2(NUM_FUS)-1:0]  alloc_fu,
    input  logic [NUM_ROWS-1:0]         request_vector,
    input  logic [NUM_FUS-1:0]          fu_busy,
    input  logic                        flush,
    input  logic                        issue_ready,
    output logic                        issue_valid,
    output logic [$clog2(NUM_ROWS)-1:0] issue_row,
    output logic [$clog2(NUM_FUS)-1:0]  issue_fu,
    output logic                        free_en,
    output logic [$clog2(NUM_ROWS)-1:0] free_row_index,
    output logic [$clog2(NUM_ROWS):0]   occupancy
);

    localparam int RW = $clog2(NUM_ROWS);
    localparam int FW = $clog2(NUM_FUS);
    localparam int OW = RW + 1;

    logic [NUM_ROWS-1:0]         valid_q, valid_d, cand, oldest, grant;
    logic [NUM_ROWS-1:0][FW-1:0] fu_q;
    logic                        sel_en;
    logic [RW-1:0]               win_row;
    logic [OW-1:0]               occ_d;

    always_comb begin
        cand = '0;
        for (int r = 0; r < NUM_ROWS; r++)
            cand[r] = valid_q[r] & request_vector[r] & ~fu_busy[fu_q[r]];
    end

    age_matrix #(.NUM_ROWS(NUM_ROWS)) u_age (
        .clk          (clk),
        .rst          (rst),
        .clear        (flush),
        .alloc_en     (alloc_en),
        .alloc_row    (alloc_row),
        .valid        (valid_q),
        .dealloc      (grant),
        .cand         (cand),
        .oldest_onehot(oldest)
    );

    // Selection only when the output register is empty or drains this cycle.
    always_comb begin
        sel_en  = !issue_valid || issue_ready;
        grant   = sel_en ? oldest : '0;
        win_row = '0;
        for (int r = 0; r < NUM_ROWS; r++)
            if (grant[r]) win_row = RW'(r);
        valid_d = valid_q & ~grant;
        if (alloc_en) valid_d[alloc_row] = 1'b1;
        occ_d = '0;
        for (int r = 0; r < NUM_ROWS; r++)
            occ_d = occ_d + OW'(valid_d[r]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q        <= '0;
            fu_q           <= '0;
            issue_valid    <= 1'b0;
            issue_row      <= '0;
            issue_fu       <= '0;
            free_en        <= 1'b0;
            free_row_index <= '0;
            occupancy      <= '0;
        end else if (flush) begin
            valid_q     <= '0;
            issue_valid <= 1'b0;
            free_en     <= 1'b0;
            occupancy   <= '0;
        end else begin
            valid_q   <= valid_d;
            occupancy <= occ_d;
            free_en   <= 1'b0;
            if (alloc_en) fu_q[alloc_row] <= alloc_fu;
            if (sel_en) begin
                issue_valid <= |grant;
                if (|grant) begin
                    issue_row      <= win_row;
                    issue_fu       <= fu_q[win_row];
                    free_en        <= 1'b1;
                    free_row_index <= win_row;
                end
            end
        end
    end

    // Allocating over a live row (including one being selected) is protocol misuse.
    always_ff @(posedge clk) begin
        if (!rst && !flush && alloc_en) begin
            assert (!valid_q[alloc_row]);
            assert (!grant[alloc_row]);
        end
    end

endmodule

// File: tb/tb_issue_select.sv
// Directed scoreboard bench for issue_select: expected issues queued at drive time, popped on free_en.
module tb_issue_select;

    localparam int NR = 8;
    localparam int NF = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          alloc_en;
    logic [2:0]    alloc_row;
    logic [1:0]    alloc_fu;
    logic [NR-1:0] request_vector;
    logic [NF-1:0] fu_busy;
    logic          flush;
    logic          issue_ready;
    logic          issue_valid;
    logic [2:0]    issue_row;
    logic [1:0]    issue_fu;
    logic          free_en;
    logic [2:0]    free_row_index;
    logic [3:0]    occupancy;

    typedef struct {
        int row;
        int fu;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    issue_select #(.NUM_ROWS(NR), .NUM_FUS(NF)) dut (
        .clk           (clk),
        .rst           (rst),
        .alloc_en      (alloc_en),
        .alloc_row     (alloc_row),
        .alloc_fu      (alloc_fu),
        .request_vector(request_vector),
        .fu_busy       (fu_busy),
        .flush         (flush),
        .issue_ready   (issue_ready),
        .issue_valid   (issue_valid),
        .issue_row     (issue_row),
        .issue_fu      (issue_fu),
        .free_en       (free_en),
        .free_row_index(free_row_index),
        .occupancy     (occupancy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push(input int r, input int f);
        sb.push_back(exp_t'{row: r, fu: f});
    endtask

    // One clock; every free_en pulse must match the head of the scoreboard.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (free_en === 1'b1) begin
            chk("free_implies_valid", 32'(issue_valid), 1);
            if (sb.size() == 0) begin
                chk("unexpected_free_row", 32'(free_row_index), 32'hffff);
            end else begin
                e = sb.pop_front();
                chk("issue_row", 32'(issue_row), e.row);
                chk("issue_fu", 32'(issue_fu), e.fu);
                chk("free_row_index", 32'(free_row_index), e.row);
            end
        end
    endtask

    task automatic alloc(input int r, input int f);
        alloc_en  = 1'b1;
        alloc_row = 3'(r);
        alloc_fu  = 2'(f);
        tick();
        alloc_en  = 1'b0;
    endtask

    initial begin
        rst = 1'b1; alloc_en = 1'b0; alloc_row = '0; alloc_fu = '0;
        request_vector = '0; fu_busy = '0; flush = 1'b0; issue_ready = 1'b1;
        tick(); tick();
        chk("rst_issue_valid", 32'(issue_valid), 0);
        chk("rst_issue_row", 32'(issue_row), 0);
        chk("rst_issue_fu", 32'(issue_fu), 0);
        chk("rst_free_en", 32'(free_en), 0);
        chk("rst_free_row", 32'(free_row_index), 0);
        chk("rst_occupancy", 32'(occupancy), 0);
        rst = 1'b0;

        // Oldest-first ordering 3, 1, 5
        alloc(3, 0); alloc(1, 0); alloc(5, 0);
        chk("occ_3", 32'(occupancy), 3);
        request_vector = 8'b0010_1010;
        push(3, 0); push(1, 0); push(5, 0);
        tick(); chk("occ_2", 32'(occupancy), 2);
        tick(); chk("occ_1", 32'(occupancy), 1);
        tick(); chk("occ_0", 32'(occupancy), 0);
        request_vector = '0;
        tick(); chk("idle_valid_a", 32'(issue_valid), 0);

        // Busy FU lets the younger row go first
        alloc(2, 1); alloc(6, 0);
        fu_busy = 4'b0010; request_vector = 8'b0100_0100;
        push(6, 0);
        tick();
        fu_busy = '0;
        push(2, 1);
        tick();
        request_vector = '0;
        tick(); chk("idle_valid_b", 32'(issue_valid), 0);

        // Hold with issue_ready low
        alloc(4, 2); alloc(0, 3);
        issue_ready = 1'b0; request_vector = 8'b0001_0001;
        push(4, 2);
        tick();
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("hold_valid", 32'(issue_valid), 1);
            chk("hold_row", 32'(issue_row), 4);
            chk("hold_free_en", 32'(free_en), 0);
        end
        issue_ready = 1'b1;
        push(0, 3);
        tick();
        request_vector = '0;
        tick(); chk("idle_valid_c", 32'(issue_valid), 0);

        // A freshly allocated row is not a candidate in its alloc cycle
        alloc_en = 1'b1; alloc_row = 3'd1; alloc_fu = 2'd0; request_vector = 8'b0000_0010;
        tick();
        alloc_en = 1'b0;
        chk("new_row_not_cand", 32'(issue_valid), 0);
        push(1, 0);
        tick();
        request_vector = '0;

        // Alloc row 0 while row 7 is selected; row 0 becomes youngest
        alloc(7, 1); alloc(2, 2);
        alloc_en = 1'b1; alloc_row = 3'd0; alloc_fu = 2'd0;
        request_vector = 8'b1000_0101;
        push(7, 1);
        tick();
        alloc_en = 1'b0;
        chk("occ_alloc_sel", 32'(occupancy), 2);
        push(2, 2);
        tick();
        push(0, 0);
        tick();
        request_vector = '0;
        tick(); chk("idle_valid_d", 32'(issue_valid), 0);

        // Fill all rows, then flush while an issue is presented
        for (int i = 0; i < NR; i++) alloc(i, i % NF);
        chk("occ_full", 32'(occupancy), 8);
        issue_ready = 1'b0; request_vector = '1;
        push(0, 0);
        tick();
        chk("occ_7", 32'(occupancy), 7);
        flush = 1'b1;
        tick();
        chk("flush_occ", 32'(occupancy), 0);
        chk("flush_valid", 32'(issue_valid), 0);
        chk("flush_free_en", 32'(free_en), 0);
        flush = 1'b0; request_vector = '0; issue_ready = 1'b1;
        tick();
        chk("post_flush_valid", 32'(issue_valid), 0);
        chk("post_flush_occ", 32'(occupancy), 0);

        // Reset in the middle of a hold
        alloc(3, 2);
        issue_ready = 1'b0; request_vector = 8'b0000_1000;
        push(3, 2);
        tick();
        request_vector = '0;
        tick(); chk("pre_rst_hold", 32'(issue_valid), 1);
        rst = 1'b1;
        tick();
        chk("mid_rst_valid", 32'(issue_valid), 0);
        chk("mid_rst_row", 32'(issue_row), 0);
        chk("mid_rst_fu", 32'(issue_fu), 0);
        chk("mid_rst_free_en", 32'(free_en), 0);
        chk("mid_rst_free_row", 32'(free_row_index), 0);
        chk("mid_rst_occ", 32'(occupancy), 0);
        rst = 1'b0; issue_ready = 1'b1;
        alloc(5, 1);
        request_vector = 8'b0010_0000;
        push(5, 1);
        tick();
        request_vector = '0;
        tick(); chk("idle_valid_e", 32'(issue_valid), 0);

        chk("sb_drained", 32'(sb.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
